// File: rtl/input_conditioner_pkg.sv
// Shared types and sizing helpers for the input conditioner.
package input_conditioner_pkg;

   // Scan sequence: discharge the pads, let them settle, take one sample.
   typedef enum logic [1:0] {
      DISCHARGE,
      SETTLE,
      SAMPLE
   } scan_state_t;

   // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Pad-side and result signals of one conditioned bank.
interface input_conditioner_if #(
   parameter int unsigned SIZE = 5
);
   logic [SIZE-1:0] pin_in;
   logic            pin_drive_low;
   logic [SIZE-1:0] state;
   logic [SIZE-1:0] rise;
   logic [SIZE-1:0] fall;
   logic            sample_strobe;

   // Conditioner side: reads the pads, drives the results.
   modport master (
      input  pin_in,
      output pin_drive_low,
      output state,
      output rise,
      output fall,
      output sample_strobe
   );

   // Consumer side: owns the tristate pads, reads the results.
   modport slave (
      output pin_in,
      input  pin_drive_low,
      input  state,
      input  rise,
      input  fall,
      input  sample_strobe
   );
endinterface

// File: rtl/input_conditioner_debounce_channel.sv
// One debounced channel: accepts a new level after DEBOUNCE_SCANS
// consecutive differing samples and pulses rise/fall for one cycle.
module debounce_channel
   import input_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sample_en,
   input  logic sample,
   output logic state,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = cnt_width(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   logic [CNT_W-1:0] cnt;

   // Count consecutive disagreeing samples; any agreeing sample restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         state <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sample_en) begin
            if (sample == state) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               state <= sample;
               cnt   <= '0;
               rise  <= sample;
               fall  <= ~sample;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Periodically discharges a bank of floating pads, releases them, samples
// after a settle time and debounces each channel independently.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int unsigned SIZE             = 5,
   parameter int unsigned DISCHARGE_CYCLES = 4,
   parameter int unsigned SETTLE_CYCLES    = 16,
   parameter int unsigned DEBOUNCE_SCANS   = 4
) (
   input logic                 clk,
   input logic                 rst,
   input_conditioner_if.master bus
);

   localparam int unsigned PHASE_W = cnt_width(max_u(DISCHARGE_CYCLES, SETTLE_CYCLES));
   localparam logic [PHASE_W-1:0] DIS_LAST = PHASE_W'(DISCHARGE_CYCLES - 1);
   localparam logic [PHASE_W-1:0] SET_LAST = PHASE_W'(SETTLE_CYCLES - 1);

   scan_state_t      scan;
   logic [PHASE_W-1:0] phase;
   logic             drive_low;
   logic             strobe;
   logic [SIZE-1:0]  sync1;
   logic [SIZE-1:0]  sync2;
   logic [SIZE-1:0]  state_w;
   logic [SIZE-1:0]  rise_w;
   logic [SIZE-1:0]  fall_w;

   // Two-flop synchroniser, running every cycle regardless of scan phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= bus.pin_in;
         sync2 <= sync1;
      end
   end

   // Scan FSM; drive_low/strobe are set alongside the transition into the
   // state they belong to, so they are registered yet aligned with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan      <= DISCHARGE;
         phase     <= '0;
         drive_low <= 1'b1;
         strobe    <= 1'b0;
      end else begin
         case (scan)
            DISCHARGE: begin
               strobe <= 1'b0;
               if (phase == DIS_LAST) begin
                  scan      <= SETTLE;
                  phase     <= '0;
                  drive_low <= 1'b0;
               end else begin
                  phase     <= phase + 1'b1;
                  drive_low <= 1'b1;
               end
            end
            SETTLE: begin
               drive_low <= 1'b0;
               if (phase == SET_LAST) begin
                  scan   <= SAMPLE;
                  phase  <= '0;
                  strobe <= 1'b1;
               end else begin
                  phase  <= phase + 1'b1;
                  strobe <= 1'b0;
               end
            end
            SAMPLE: begin
               scan      <= DISCHARGE;
               phase     <= '0;
               drive_low <= 1'b1;
               strobe    <= 1'b0;
            end
            default: begin
               scan      <= DISCHARGE;
               phase     <= '0;
               drive_low <= 1'b1;
               strobe    <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < SIZE; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .sample_en(strobe),
         .sample   (sync2[i]),
         .state    (state_w[i]),
         .rise     (rise_w[i]),
         .fall     (fall_w[i])
      );
   end

   assign bus.pin_drive_low = drive_low;
   assign bus.sample_strobe = strobe;
   assign bus.state         = state_w;
   assign bus.rise          = rise_w;
   assign bus.fall          = fall_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: default bank plus a fast 24-channel bank.
module tb_input_conditioner;

   localparam int unsigned N  = 5;
   localparam int unsigned DB = 4;
   localparam int unsigned N2 = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   input_conditioner_if #(.SIZE(N))  bus1 ();
   input_conditioner_if #(.SIZE(N2)) bus2 ();

   input_conditioner #(
      .SIZE(N), .DISCHARGE_CYCLES(4), .SETTLE_CYCLES(16), .DEBOUNCE_SCANS(DB)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   input_conditioner #(
      .SIZE(N2), .DISCHARGE_CYCLES(4), .SETTLE_CYCLES(3), .DEBOUNCE_SCANS(1)
   ) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   // Pad model: pulled to 0 while discharged, 1 while pressed, else floats at last value.
   logic [N-1:0]  pressed  = '0;
   logic [N-1:0]  pad      = '0;
   logic [N2-1:0] pressed2 = '0;
   logic [N2-1:0] pad2     = '0;

   always @(bus1.pin_drive_low or pressed) begin
      for (int i = 0; i < N; i++) begin
         if (bus1.pin_drive_low) pad[i] = 1'b0;
         else if (pressed[i])    pad[i] = 1'b1;
      end
   end

   always @(bus2.pin_drive_low or pressed2) begin
      for (int i = 0; i < N2; i++) begin
         if (bus2.pin_drive_low) pad2[i] = 1'b0;
         else if (pressed2[i])   pad2[i] = 1'b1;
      end
   end

   assign bus1.pin_in = pad;
   assign bus2.pin_in = pad2;

   int errors = 0;
   int checks = 0;

   // Reference model: a level is accepted once DB consecutive samples disagree with it.
   logic [N-1:0]  ref_state, exp_rise, exp_fall;
   int unsigned   disagree[N];
   logic [N2-1:0] ref2, exp_rise2, exp_fall2;

   task automatic model_reset();
      ref_state = '0; exp_rise = '0; exp_fall = '0;
      for (int i = 0; i < N; i++) disagree[i] = 0;
   endtask

   task automatic model_sample(input logic [N-1:0] smp);
      exp_rise = '0; exp_fall = '0;
      for (int i = 0; i < N; i++) begin
         if (smp[i] == ref_state[i]) disagree[i] = 0;
         else begin
            disagree[i] = disagree[i] + 1;
            if (disagree[i] == DB) begin
               exp_rise[i]  = smp[i];
               exp_fall[i]  = ~smp[i];
               ref_state[i] = smp[i];
               disagree[i]  = 0;
            end
         end
      end
   endtask

   // Advance to the next SAMPLE of the default bank, feed the model, land on
   // the following cycle where the updated state and pulses are visible.
   task automatic next_sample();
      int unsigned t = 0;
      @(negedge clk);
      while (bus1.sample_strobe !== 1'b1 && t < 100) begin
         @(negedge clk); t++;
      end
      checks++;
      if (bus1.sample_strobe !== 1'b1) begin
         errors++;
         $display("FAIL strobe_timeout: waited %0d cycles, required strobe within 100", t);
      end else begin
         model_sample(pressed);
      end
      @(negedge clk);
   endtask

   task automatic next_sample2();
      int unsigned t = 0;
      @(negedge clk);
      while (bus2.sample_strobe !== 1'b1 && t < 100) begin
         @(negedge clk); t++;
      end
      checks++;
      if (bus2.sample_strobe !== 1'b1) begin
         errors++;
         $display("FAIL strobe2_timeout: waited %0d cycles, required strobe within 100", t);
      end else begin
         exp_rise2 = pressed2 & ~ref2;
         exp_fall2 = ~pressed2 & ref2;
         ref2      = pressed2;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus1.pin_drive_low !== 1'b1) begin errors++; $display("FAIL reset_drive: got %b required 1", bus1.pin_drive_low); end
      checks++; if (bus1.state !== '0) begin errors++; $display("FAIL reset_state: got %b required 0", bus1.state); end
      checks++; if (bus1.rise !== '0 || bus1.fall !== '0) begin errors++; $display("FAIL reset_pulses: rise %b fall %b required 0", bus1.rise, bus1.fall); end
      checks++; if (bus1.sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b required 0", bus1.sample_strobe); end
      rst = 1'b0;
      model_reset();
      ref2 = '0;
   endtask

   task automatic test_idle();
      int unsigned bad = 0;
      int unsigned per, drv, t;
      repeat (500) begin
         @(negedge clk);
         if (bus1.state !== '0 || bus1.rise !== '0 || bus1.fall !== '0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_quiet: %0d active cycles, required 0", bad); end
      for (int k = 0; k < 3; k++) begin
         t = 0;
         while (bus1.sample_strobe !== 1'b1 && t < 100) begin @(negedge clk); t++; end
         per = 0; drv = 0;
         do begin
            @(negedge clk); per++;
            if (bus1.pin_drive_low === 1'b1) drv++;
         end while (bus1.sample_strobe !== 1'b1 && per < 100);
         checks++; if (per != 21) begin errors++; $display("FAIL scan_period: got %0d required 21", per); end
         checks++; if (drv != 4) begin errors++; $display("FAIL discharge_len: got %0d required 4", drv); end
      end
   endtask

   task automatic test_press_release();
      pressed[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         next_sample();
         checks++; if (bus1.state !== ref_state || bus1.rise !== exp_rise || bus1.fall !== exp_fall) begin
            errors++; $display("FAIL press%0d: state %b rise %b fall %b required %b %b %b", k, bus1.state, bus1.rise, bus1.fall, ref_state, exp_rise, exp_fall); end
      end
      checks++; if (bus1.rise !== 5'b00100 || bus1.state !== 5'b00100) begin errors++; $display("FAIL press_accept: rise %b state %b required 00100", bus1.rise, bus1.state); end
      @(negedge clk);
      checks++; if (bus1.rise !== '0) begin errors++; $display("FAIL rise_width: got %b required 0", bus1.rise); end
      pressed[2] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         next_sample();
         checks++; if (bus1.state !== ref_state || bus1.rise !== exp_rise || bus1.fall !== exp_fall) begin
            errors++; $display("FAIL release%0d: state %b rise %b fall %b required %b %b %b", k, bus1.state, bus1.rise, bus1.fall, ref_state, exp_rise, exp_fall); end
      end
      checks++; if (bus1.fall !== 5'b00100 || bus1.state !== '0) begin errors++; $display("FAIL release_accept: fall %b state %b required 00100/0", bus1.fall, bus1.state); end
      @(negedge clk);
      checks++; if (bus1.fall !== '0) begin errors++; $display("FAIL fall_width: got %b required 0", bus1.fall); end
   endtask

   task automatic test_bounce();
      logic [6:0] seq;
      seq = 7'b1111011;
      for (int k = 0; k < 7; k++) begin
         pressed[0] = seq[k];
         next_sample();
         checks++; if (bus1.state !== ref_state || bus1.rise !== exp_rise || bus1.fall !== exp_fall) begin
            errors++; $display("FAIL bounce%0d: state %b rise %b fall %b required %b %b %b", k, bus1.state, bus1.rise, bus1.fall, ref_state, exp_rise, exp_fall); end
         if (k == 4) begin
            checks++; if (bus1.state[0] !== 1'b0) begin errors++; $display("FAIL bounce_reject: state0 %b required 0", bus1.state[0]); end
         end
      end
      checks++; if (bus1.rise[0] !== 1'b1) begin errors++; $display("FAIL bounce_accept: rise0 %b required 1", bus1.rise[0]); end
      pressed[0] = 1'b0;
      repeat (4) next_sample();
   endtask

   task automatic test_simultaneous();
      rst = 1'b1;
      pressed = 5'b10010;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      ref2 = '0;
      repeat (4) next_sample();
      checks++; if (bus1.rise !== 5'b10010 || bus1.state !== 5'b10010) begin errors++; $display("FAIL simul_rise: rise %b state %b required 10010", bus1.rise, bus1.state); end
      pressed = 5'b11000;
      repeat (4) next_sample();
      checks++; if (bus1.rise !== 5'b01000 || bus1.fall !== 5'b00010) begin errors++; $display("FAIL simul_mixed: rise %b fall %b required 01000 00010", bus1.rise, bus1.fall); end
      checks++; if (bus1.state !== ref_state) begin errors++; $display("FAIL simul_state: got %b required %b", bus1.state, ref_state); end
      pressed = '0;
      repeat (4) next_sample();
      checks++; if (bus1.fall !== 5'b11000 || bus1.state !== '0) begin errors++; $display("FAIL simul_release: fall %b state %b required 11000/0", bus1.fall, bus1.state); end
   endtask

   task automatic test_reset_mid();
      pressed = 5'b00100;
      repeat (3) next_sample();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      ref2 = '0;
      checks++; if (bus1.pin_drive_low !== 1'b1) begin errors++; $display("FAIL midrst_drive: got %b required 1", bus1.pin_drive_low); end
      checks++; if (bus1.state !== '0 || bus1.rise !== '0 || bus1.fall !== '0) begin errors++; $display("FAIL midrst_clear: state %b rise %b fall %b required 0", bus1.state, bus1.rise, bus1.fall); end
      for (int k = 0; k < 4; k++) begin
         next_sample();
         if (k == 2) begin
            checks++; if (bus1.state !== '0) begin errors++; $display("FAIL midrst_restart: state %b required 0", bus1.state); end
         end
      end
      checks++; if (bus1.rise !== 5'b00100) begin errors++; $display("FAIL midrst_accept: rise %b required 00100", bus1.rise); end
      pressed = '0;
      repeat (4) next_sample();
   endtask

   task automatic test_random();
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(3) == 0) pressed[i] = ~pressed[i];
         next_sample();
         checks++; if (bus1.state !== ref_state || bus1.rise !== exp_rise || bus1.fall !== exp_fall) begin
            errors++; $display("FAIL random%0d: state %b rise %b fall %b required %b %b %b", k, bus1.state, bus1.rise, bus1.fall, ref_state, exp_rise, exp_fall); end
      end
   endtask

   task automatic test_sweep();
      int unsigned per, t;
      t = 0;
      @(negedge clk);
      while (bus2.sample_strobe !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      per = 0;
      do begin @(negedge clk); per++; end while (bus2.sample_strobe !== 1'b1 && per < 100);
      checks++; if (per != 8) begin errors++; $display("FAIL sweep_period: got %0d required 8", per); end
      next_sample2();
      pressed2 = 24'h800400;
      next_sample2();
      checks++; if (bus2.state !== 24'h800400 || bus2.rise !== 24'h800400) begin errors++; $display("FAIL sweep_press: state %h rise %h required 800400", bus2.state, bus2.rise); end
      for (int k = 0; k < 8; k++) begin
         pressed2 = N2'($urandom);
         next_sample2();
         checks++; if (bus2.state !== ref2 || bus2.rise !== exp_rise2 || bus2.fall !== exp_fall2) begin
            errors++; $display("FAIL sweep%0d: state %h rise %h fall %h required %h %h %h", k, bus2.state, bus2.rise, bus2.fall, ref2, exp_rise2, exp_fall2); end
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_press_release();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
